// File: rtl/ttt_keypad_scan.sv
// ttt_keypad_scan -- 3x3 matrix keypad scanner with debounce for a tic-tac-toe board.
//
// Drives one keypad row at a time and samples the three column lines at the
// end of each row's dwell. The three row samples make a 9-bit snapshot of the
// whole board. A press FSM advances once per completed scan. It accepts a
// single key after DEBOUNCE_SCANS identical scans and reports it as a
// one-cycle pulse. It then waits for DEBOUNCE_SCANS empty scans before it
// re-arms. Chords (two or more keys) never produce a report.
//
// Parameters
//   SCAN_DIV       clock cycles each row is driven (>= 4)
//   DEBOUNCE_SCANS identical full scans needed to accept a press/release (>= 1)
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   col_in     [2:0] column sense, active-high
//   row_out    [2:0] one-hot row drive, active-high
//   b_pulse    [8:0] one-hot single-cycle press event, bit n = key n
//   key_valid  high together with any b_pulse bit
//   key_idx    [3:0] index (row*3+col) of the pulsed key, 0 otherwise
//
// Build option
//   TTT_KEY_SYNC_EN  when defined, col_in passes through a two-flop
//                    synchronizer before it is sampled.

module ttt_keypad_scan #(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] col_in,
   output logic [2:0] row_out,
   output logic [8:0] b_pulse,
   output logic       key_valid,
   output logic [3:0] key_idx
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONFIRM = 2'd1,
      HELD    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   logic [2:0] col;

`ifdef TTT_KEY_SYNC_EN
   // column synchronizer stages
   logic [2:0] sync_p0;
   logic [2:0] sync_p1;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= col_in;
         sync_p1 <= sync_p0;
      end
   end

   assign col = sync_p1;
`else
   assign col = col_in;
`endif

   // scan stage: row drive, dwell timing, snapshot capture
   logic [1:0]    row;
   logic [DW-1:0] dwell;
   logic [8:0]    snapshot;
   logic          scan_done;
   logic          dwell_end;

   assign dwell_end = (dwell == DW'(SCAN_DIV - 1));
   assign row_out   = 3'b001 << row;

   always_ff @(posedge clk) begin
      if (reset) begin
         row       <= 2'd0;
         dwell     <= '0;
         snapshot  <= '0;
         scan_done <= 1'b0;
      end else begin
         // strobe lands on the cycle after the row-2 sample, when the
         // snapshot already holds the complete scan
         scan_done <= dwell_end && (row == 2'd2);
         if (dwell_end) begin
            dwell <= '0;
            row   <= (row == 2'd2) ? 2'd0 : row + 2'd1;
            case (row)
               2'd0:    snapshot[2:0] <= col;
               2'd1:    snapshot[5:3] <= col;
               default: snapshot[8:6] <= col;
            endcase
         end else begin
            dwell <= dwell + DW'(1);
         end
      end
   end

   // press FSM stage: debounce on whole-scan snapshots
   state_t        state;
   state_t        state_d;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_d;
   logic [CW-1:0] cnt_inc;
   logic          cnt_full;
   logic [3:0]    cand;
   logic [3:0]    cand_d;
   logic [8:0]    cand_mask;
   logic          report;
   logic          snap_zero;
   logic          snap_one;
   logic [3:0]    snap_idx;

   assign snap_zero = (snapshot == 9'd0);
   // exactly one bit set: nonzero and clearing the lowest set bit leaves zero
   assign snap_one  = !snap_zero && ((snapshot & (snapshot - 9'd1)) == 9'd0);
   assign cand_mask = 9'd1 << cand;
   assign cnt_inc   = cnt + CW'(1);
   assign cnt_full  = (cnt_inc == CW'(DEBOUNCE_SCANS));

   // only meaningful when snap_one is true
   always_comb begin
      snap_idx = 4'd0;
      for (int i = 0; i < 9; i++) begin
         if (snapshot[i]) snap_idx = 4'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         cand  <= 4'd0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         cand  <= cand_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      cand_d  = cand;
      report  = 1'b0;
      if (scan_done) begin
         case (state)
            IDLE: begin
               if (snap_one) begin
                  cand_d = snap_idx;
                  if (DEBOUNCE_SCANS == 1) begin
                     report  = 1'b1;
                     state_d = HELD;
                  end else begin
                     cnt_d   = CW'(1);
                     state_d = CONFIRM;
                  end
               end else if (!snap_zero) begin
                  state_d = HELD;
               end
            end
            CONFIRM: begin
               if (snapshot == cand_mask) begin
                  cnt_d = cnt_inc;
                  if (cnt_full) begin
                     report  = 1'b1;
                     state_d = HELD;
                  end
               end else if (snap_zero) begin
                  state_d = IDLE;
               end else begin
                  state_d = HELD;
               end
            end
            HELD: begin
               if (snap_zero) begin
                  if (DEBOUNCE_SCANS == 1) begin
                     state_d = IDLE;
                  end else begin
                     cnt_d   = CW'(1);
                     state_d = RELEASE;
                  end
               end
            end
            RELEASE: begin
               if (snap_zero) begin
                  cnt_d = cnt_inc;
                  if (cnt_full) state_d = IDLE;
               end else begin
                  state_d = HELD;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // report stage: registered one-cycle event
   always_ff @(posedge clk) begin
      if (reset) begin
         b_pulse   <= '0;
         key_valid <= 1'b0;
         key_idx   <= 4'd0;
      end else begin
         key_valid <= report;
         key_idx   <= report ? cand_d : 4'd0;
         b_pulse   <= report ? (9'd1 << cand_d) : 9'd0;
      end
   end

endmodule

// File: tb/tb_ttt_keypad_scan.sv
// tb_ttt_keypad_scan -- self-checking bench for ttt_keypad_scan.
//
// A keypad model turns the bench's 9-bit "keys" vector into column levels for
// whichever row the DUT is driving. A behavioural reference works from scan
// timing and scan-level press/release rules. It predicts row_out and the press
// outputs for every cycle. Directed scenarios pin the reference with literal
// expectations, and a randomized phase follows them.

module tb_ttt_keypad_scan;

   localparam int SD = 4;
   localparam int DS = 2;
`ifdef TTT_KEY_SYNC_EN
   localparam int DLY = 2;
`else
   localparam int DLY = 0;
`endif

   logic       clk;
   logic       reset;
   logic [2:0] col_in;
   logic [2:0] row_out;
   logic [8:0] b_pulse;
   logic       key_valid;
   logic [3:0] key_idx;

   logic [8:0] keys;

   ttt_keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
      .clk       (clk),
      .reset     (reset),
      .col_in    (col_in),
      .row_out   (row_out),
      .b_pulse   (b_pulse),
      .key_valid (key_valid),
      .key_idx   (key_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // keypad matrix: a closed key connects its row line to its column line
   assign col_in = (row_out == 3'b001) ? keys[2:0] :
                   (row_out == 3'b010) ? keys[5:3] :
                   (row_out == 3'b100) ? keys[8:6] : 3'b000;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   int         pulse_cnt = 0;
   int         last_t    = -1;
   logic [8:0] last_b    = '0;
   logic [3:0] last_idx  = '0;

   logic rst_seen = 1'b1;
   always @(posedge clk) rst_seen <= reset;

   // reference model state
   int         t = 0;
   int         row_m;
   int         exp_pulse_t = -1;
   int         exp_idx = 0;
   bit         armed = 1;
   int         run_len = 0;
   int         zero_run = 0;
   logic [8:0] prev_scan = '0;
   logic [8:0] scan_acc = '0;
   logic [8:0] h1 = '0;
   logic [8:0] h2 = '0;
   logic [8:0] src;
   logic [2:0] exp_row;
   logic [8:0] exp_b;
   logic [3:0] exp_k;
   bit         exp_hit;
   bit         rep;

   always @(negedge clk) begin
      if (rst_seen) begin
         t = 0;
         exp_pulse_t = -1;
         armed = 1;
         run_len = 0;
         zero_run = 0;
         prev_scan = '0;
         scan_acc = '0;
      end else begin
         t = t + 1;
      end

      row_m   = (t / SD) % 3;
      exp_row = 3'b001 << row_m;
      exp_hit = (exp_pulse_t == t);
      exp_b   = exp_hit ? (9'd1 << exp_idx) : 9'd0;
      exp_k   = exp_hit ? 4'(exp_idx) : 4'd0;

      if (chk_en) begin
         n_tests++;
         if ({row_out, b_pulse, key_valid, key_idx} !== {exp_row, exp_b, exp_hit, exp_k}) begin
            n_fail++;
            $display("FAIL per_cycle t=%0d: row_out=%b b_pulse=%h key_valid=%b key_idx=%0d, expected row_out=%b b_pulse=%h key_valid=%b key_idx=%0d",
                     t, row_out, b_pulse, key_valid, key_idx, exp_row, exp_b, exp_hit, exp_k);
         end
         if (key_valid === 1'b1) begin
            pulse_cnt++;
            last_t   = t;
            last_b   = b_pulse;
            last_idx = key_idx;
         end
      end

      // column sampling at the end of each row dwell
      if (t % SD == SD - 1) begin
         src = (DLY == 2) ? h2 : keys;
         scan_acc[row_m*3 +: 3] = src[row_m*3 +: 3];
         if (row_m == 2) begin
            rep = 0;
            if (armed) begin
               if (scan_acc == 9'd0) begin
                  run_len = 0;
               end else if ($countones(scan_acc) == 1) begin
                  if (scan_acc == prev_scan) run_len = run_len + 1;
                  else if (prev_scan == 9'd0) run_len = 1;
                  else begin armed = 0; zero_run = 0; end
                  if (armed && run_len == DS) begin
                     rep = 1;
                     armed = 0;
                     zero_run = 0;
                  end
               end else begin
                  armed = 0;
                  zero_run = 0;
               end
            end else begin
               if (scan_acc == 9'd0) begin
                  zero_run = zero_run + 1;
                  if (zero_run == DS) begin
                     armed = 1;
                     run_len = 0;
                  end
               end else begin
                  zero_run = 0;
               end
            end
            if (rep) begin
               exp_pulse_t = t + 2;
               for (int i = 0; i < 9; i++) if (scan_acc[i]) exp_idx = i;
            end
            prev_scan = scan_acc;
         end
      end
      h2 = h1;
      h1 = keys;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // leaves the caller in the first cycle after reset (model t = 0)
   task automatic do_reset(input int n);
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (n) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   int a;
   int b;
   int r;

   initial begin
      reset = 1'b1;
      keys  = '0;
      @(posedge clk);
      #1 chk_en = 1;
      @(posedge clk);
      #1 reset = 1'b0;

      // idle scanning
      chk("row_t0", 32'(row_out), 32'b001);
      cycles(4);  chk("row_t4", 32'(row_out), 32'b010);
      cycles(4);  chk("row_t8", 32'(row_out), 32'b100);
      cycles(4);  chk("row_t12", 32'(row_out), 32'b001);
      cycles(88); chk("idle_no_pulse", pulse_cnt, 0);

      // key 4 held for 5 scans
      do_reset(1);
      keys = 9'h010; pulse_cnt = 0;
      cycles(60);
      keys = 9'h000;
      chk("k4_count", pulse_cnt, 1);
      chk("k4_b_pulse", 32'(last_b), 32'h010);
      chk("k4_idx", 32'(last_idx), 4);
      chk("k4_latency", last_t, 25);

      // key 8 bounce then stable
      do_reset(1);
      keys = 9'h100; pulse_cnt = 0;
      cycles(12); keys = 9'h000;
      cycles(12); keys = 9'h100;
      cycles(12); chk("k8_bounce_none", pulse_cnt, 0);
      cycles(24); keys = 9'h000;
      chk("k8_count", pulse_cnt, 1);
      chk("k8_b_pulse", 32'(last_b), 32'h100);
      chk("k8_time", last_t, 49);

      // chord 0+2, release, then key 2 alone
      do_reset(1);
      keys = 9'h005; pulse_cnt = 0;
      cycles(48); chk("chord_none", pulse_cnt, 0);
      keys = 9'h000; cycles(24);
      keys = 9'h004; cycles(24);
      keys = 9'h000; cycles(12);
      chk("k2_count", pulse_cnt, 1);
      chk("k2_idx", 32'(last_idx), 2);
      chk("k2_time", last_t, 97);

      // key 5: no auto-repeat, short release does not re-arm
      do_reset(1);
      keys = 9'h020; pulse_cnt = 0;
      cycles(120);
      chk("k5_single", pulse_cnt, 1);
      chk("k5_b_pulse", 32'(last_b), 32'h020);
      keys = 9'h000; cycles(12);
      keys = 9'h020; cycles(36);
      chk("k5_short_release", pulse_cnt, 1);
      keys = 9'h000; cycles(24);
      keys = 9'h020; cycles(36);
      keys = 9'h000;
      chk("k5_repress", pulse_cnt, 2);
      chk("k5_idx", 32'(last_idx), 5);

      // reset during the second confirming scan of key 1
      do_reset(1);
      keys = 9'h002; pulse_cnt = 0;
      cycles(18);
      do_reset(1);
      keys = 9'h000;
      chk("rst_row", 32'(row_out), 32'b001);
      cycles(48);
      chk("rst_no_pulse", pulse_cnt, 0);

      // randomized key activity
      do_reset(1);
      repeat (80) begin
         r = $urandom_range(0, 9);
         if (r < 3) begin
            keys = 9'h000;
         end else if (r < 8) begin
            keys = 9'd1 << $urandom_range(0, 8);
         end else begin
            a = $urandom_range(0, 8);
            b = (a + $urandom_range(1, 8)) % 9;
            keys = (9'd1 << a) | (9'd1 << b);
         end
         cycles($urandom_range(1, 60));
         if ($urandom_range(0, 29) == 0) begin
            do_reset($urandom_range(1, 2));
         end
      end
      keys = 9'h000;
      cycles(40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ttt_keypad_scan.md
TTT_KEYPAD_SCAN -- requirements
Module: ttt_keypad_scan

Interface
REQ-001 Parameters SHALL be: SCAN_DIV, default 1000, clock cycles each row is driven (legal minimum 4); DEBOUNCE_SCANS, default 4, consecutive identical full scans needed to accept a press or release (legal minimum 1).
REQ-002 The module SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- col_in  input  3  keypad column sense, active-high (external pull-downs).
- row_out  output  3  one-hot keypad row drive, active-high.
- b_pulse  output  9  one-hot, single-cycle press event; bit n equals game button bn.
- key_valid  output  1  high in the same cycle as any b_pulse bit.
- key_idx  output  4  index 0..8 of the pulsed key; 0 when key_valid is low.

Function
REQ-003 Key index SHALL be row*3+col (row 0 = row_out[0], col 0 = col_in[0]), so index 0 is top-left and 8 is bottom-right.
REQ-004 Row drive: a row counter 0..2 SHALL drive row_out = 1<<row, and a dwell counter 0..SCAN_DIV-1 SHALL hold each row.
REQ-005 Row order SHALL wrap 2->0; one full scan SHALL take 3*SCAN_DIV cycles.
REQ-006 On the cycle dwell==SCAN_DIV-1, the sensed columns SHALL be registered into snapshot bits [row*3+2:row*3].
REQ-007 A registered strobe scan_done SHALL assert for one cycle, on the cycle after the row-2 sample.
REQ-008 The press FSM SHALL have states IDLE, CONFIRM, HELD and RELEASE, SHALL advance only on scan_done, and SHALL use a stability counter cnt.
REQ-009 IDLE: if the snapshot has exactly one bit set, the FSM SHALL latch that bit as cand, set cnt=1 and go to CONFIRM (or report directly per REQ-011 when DEBOUNCE_SCANS==1).
REQ-010 IDLE: a zero snapshot SHALL keep IDLE; two or more bits set SHALL go to HELD.
REQ-011 CONFIRM: if snapshot==cand, cnt SHALL increment; when cnt reaches DEBOUNCE_SCANS the key SHALL be reported and the FSM SHALL go to HELD.
REQ-012 CONFIRM: a zero snapshot SHALL return to IDLE; any other non-matching snapshot SHALL go to HELD with no report.
REQ-013 Report: b_pulse SHALL equal 1<<cand, key_valid=1 and key_idx=cand for exactly one cycle, the cycle after the deciding scan_done.
REQ-014 HELD: a zero snapshot SHALL set cnt=1 and go to RELEASE (or IDLE directly when DEBOUNCE_SCANS==1); a nonzero snapshot SHALL stay in HELD.
REQ-015 RELEASE: a zero snapshot SHALL increment cnt, and reaching DEBOUNCE_SCANS SHALL go to IDLE; a nonzero snapshot SHALL go to HELD.
REQ-016 At most one press SHALL be reported per physical press, with no auto-repeat; multi-key chords SHALL never report.
REQ-017 Press latency, from stable column contact to pulse, SHALL be at most (DEBOUNCE_SCANS+1)*3*SCAN_DIV+2 cycles (+2 more with the synchronizer).

Reset
REQ-018 While reset is high, the following SHALL hold at the next edge: row=0, row_out=3'b001, dwell=0, snapshot=0, scan_done=0, cnt=0, cand=0, FSM=IDLE, b_pulse=0, key_valid=0, key_idx=0, and synchronizer flops=0.
REQ-019 Reset asserted mid-scan or mid-debounce SHALL discard all partial state and emit no pulse; scanning SHALL restart at row 0 on the first cycle after reset deasserts.

Configuration
REQ-020 With macro TTT_KEY_SYNC_EN defined, col_in SHALL pass through a two-flop synchronizer before sampling, so the sample reflects col_in from two cycles earlier.
REQ-021 Without TTT_KEY_SYNC_EN, col_in SHALL be sampled directly; all other behaviour SHALL be identical.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2)
REQ-022 Reset, then idle for 100 cycles -> row_out cycles 001,010,100 every 4 cycles; b_pulse=0 throughout.
REQ-023 Key 4 held (col_in[1] high while row_out=010) for 5 scans -> exactly one cycle with b_pulse=9'h010, key_valid=1, key_idx=4, at the latency bound of REQ-017.
REQ-024 Key 8 closed for 1 scan, open 1 scan, closed 1 scan (bounce) -> no pulse; after 2 further stable scans -> one pulse with b_pulse=9'h100.
REQ-025 Keys 0 and 2 held together for 4 scans, then released for 2 scans, then key 2 alone for 2 scans -> no pulse during the chord; then one pulse with key_idx=2.
REQ-026 Key 5 held 10 scans -> one pulse only; released 1 scan, pressed again -> no new pulse until a 2-scan release precedes it.
REQ-027 Reset asserted for 1 cycle during the second confirming scan of key 1 -> no pulse; row_out=001 after reset.
